// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 LSB-first UART transmitter with input FIFO
// Frames are sent back-to-back while bytes are queued; bit period is latched per frame.
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [15:0]                   clks_per_bit_i,
  input  logic                          tx_valid_i,
  input  logic [7:0]                    tx_byte_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          tx_active_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [1:0]  state_q;
  logic [15:0] bit_cnt_q;
  logic [15:0] cpb_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;

  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        bit_last;
  logic [15:0] cpb_eff;

  assign fifo_empty   = (count_q == '0);
  assign tx_ready_o   = (count_q != CW'(FIFO_DEPTH));
  assign fifo_level_o = count_q;
  assign push         = tx_valid_i & tx_ready_o;
  assign bit_last     = (bit_cnt_q == cpb_q - 16'd1);
  assign cpb_eff      = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;

  // Pop only from registered FIFO state, so a push in the same cycle is never seen here.
  assign pop = !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_last));

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_byte_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 16'd0;
      cpb_q     <= 16'd1;
      idx_q     <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            cpb_q     <= cpb_eff;
            bit_cnt_q <= 16'd0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_last) begin
            bit_cnt_q <= 16'd0;
            idx_q     <= 3'd0;
            state_q   <= ST_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_last) begin
            bit_cnt_q <= 16'd0;
            if (idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_last) begin
            bit_cnt_q <= 16'd0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              cpb_q   <= cpb_eff;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Line level decodes straight from state registers so reset forces it high at once.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      ST_START: tx_o = 1'b0;
      ST_DATA:  tx_o = shift_q[idx_q];
      default:  tx_o = 1'b1;
    endcase
  end

  assign tx_active_o = (state_q != ST_IDLE);
  assign tx_done_o   = (state_q == ST_STOP) && bit_last;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed vector bench for uart_transmitter
// Frame lines are stored as {stop, data[7:0], start}, bit 0 sent first.
module tb_uart_transmitter;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpb;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        tx_line;
  logic        tx_active;
  logic        tx_done;
  logic [2:0]  level;

  uart_transmitter #(.FIFO_DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clks_per_bit_i (cpb),
    .tx_valid_i     (tx_valid),
    .tx_byte_i      (tx_byte),
    .tx_ready_o     (tx_ready),
    .tx_o           (tx_line),
    .tx_active_o    (tx_active),
    .tx_done_o      (tx_done),
    .fifo_level_o   (level)
  );

  typedef struct {
    logic [15:0] cpb;
    logic [7:0]  data;
    logic [9:0]  line;
    int          eff;
  } vec_t;

  vec_t       vecs[5];
  logic [9:0] exp_line[8];
  int         exp_cpb[8];
  logic [7:0] push_data[8];
  int         push_cyc[8];
  int         done_cyc[8];
  int         start_cyc;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         full_check = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Holds tx_valid until each byte is accepted; push_cyc records the accepting edge.
  task automatic push_bytes(input int n);
    int   waited;
    logic acc;
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1;
      tx_byte  = push_data[i];
      waited   = 0;
      acc      = 1'b0;
      while (!acc && waited < 2000) begin
        acc = tx_ready;
        @(posedge clk); #1;
        waited++;
      end
      if (!acc) begin
        check("push_timeout", 32'd0, 32'd1);
        break;
      end
      push_cyc[i] = cyc;
      if (full_check && i == 4) begin
        check("full_level", 32'(level), 32'd4);
        check("full_ready", 32'(tx_ready), 32'd0);
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic check_frames(input int n);
    int waited;
    int len;
    waited = 0;
    while (tx_line !== 1'b0 && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    if (tx_line !== 1'b0) begin
      check("start_timeout", 32'd0, 32'd1);
      return;
    end
    start_cyc = cyc;
    for (int f = 0; f < n; f++) begin
      len = 10 * exp_cpb[f];
      done_cyc[f] = -1;
      for (int j = 0; j < len; j++) begin
        if (!(f == 0 && j == 0)) begin
          @(posedge clk); #1;
        end
        check("tx_line", 32'(tx_line), 32'(exp_line[f][j / exp_cpb[f]]));
        check("tx_active", 32'(tx_active), 32'd1);
        check("tx_done", 32'(tx_done), 32'(j == len - 1));
        if (tx_done && done_cyc[f] < 0) done_cyc[f] = cyc;
      end
    end
  endtask

  task automatic check_idle();
    @(posedge clk); #1;
    check("idle_line", 32'(tx_line), 32'd1);
    check("idle_active", 32'(tx_active), 32'd0);
    check("idle_level", 32'(level), 32'd0);
  endtask

  initial begin
    int n_low;
    int waited;
    bit quiet_ok;
    clk = 1'b0; rst_n = 1'b0; cpb = 16'd4; tx_valid = 1'b0; tx_byte = 8'd0;

    vecs[0] = '{16'd4, 8'hA5, 10'h34A, 4};
    vecs[1] = '{16'd1, 8'h5A, 10'h2B4, 1};
    vecs[2] = '{16'd0, 8'h5A, 10'h2B4, 1};
    vecs[3] = '{16'd3, 8'h3C, 10'h278, 3};
    vecs[4] = '{16'd2, 8'hFF, 10'h3FE, 2};

    repeat (3) @(posedge clk); #1;
    check("rst_line", 32'(tx_line), 32'd1);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      cpb          = vecs[i].cpb;
      push_data[0] = vecs[i].data;
      exp_line[0]  = vecs[i].line;
      exp_cpb[0]   = vecs[i].eff;
      fork
        push_bytes(1);
        check_frames(1);
      join
      check("latency", 32'(start_cyc - push_cyc[0]), 32'd1);
      check_idle();
    end

    // Three queued bytes run back-to-back with no idle gap.
    cpb = 16'd2;
    push_data[0] = 8'h00; push_data[1] = 8'hFF; push_data[2] = 8'h3C;
    exp_line[0] = 10'h200; exp_line[1] = 10'h3FE; exp_line[2] = 10'h278;
    exp_cpb[0] = 2; exp_cpb[1] = 2; exp_cpb[2] = 2;
    fork
      push_bytes(3);
      check_frames(3);
    join
    check("done_gap0", 32'(done_cyc[1] - done_cyc[0]), 32'd20);
    check("done_gap1", 32'(done_cyc[2] - done_cyc[1]), 32'd20);
    check_idle();

    // Six bytes into a 4-deep FIFO: sixth accepted right after the second pop.
    cpb = 16'd8;
    full_check = 1'b1;
    push_data[0] = 8'h11; push_data[1] = 8'h22; push_data[2] = 8'h44;
    push_data[3] = 8'h88; push_data[4] = 8'h01; push_data[5] = 8'h80;
    exp_line[0] = 10'h222; exp_line[1] = 10'h244; exp_line[2] = 10'h288;
    exp_line[3] = 10'h310; exp_line[4] = 10'h202; exp_line[5] = 10'h300;
    for (int i = 0; i < 6; i++) exp_cpb[i] = 8;
    fork
      push_bytes(6);
      check_frames(6);
    join
    full_check = 1'b0;
    check("sixth_push", 32'(push_cyc[5] - push_cyc[0]), 32'd82);
    check_idle();

    // Bit period change mid-frame only applies from the next pop.
    cpb = 16'd4;
    push_data[0] = 8'hA5; push_data[1] = 8'h3C;
    exp_line[0] = 10'h34A; exp_line[1] = 10'h278;
    exp_cpb[0] = 4; exp_cpb[1] = 8;
    fork
      begin
        push_bytes(2);
        repeat (5) @(posedge clk);
        #1 cpb = 16'd8;
      end
      check_frames(2);
    join
    check_idle();

    // Maximum bit period, then reset mid-DATA with two bytes queued.
    cpb = 16'hFFFF;
    push_data[0] = 8'h01;
    push_bytes(1);
    waited = 0;
    while (tx_line !== 1'b0 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    n_low = 0;
    while (tx_line === 1'b0 && n_low < 70000) begin
      @(posedge clk); #1;
      n_low++;
    end
    check("start_len_ffff", 32'(n_low), 32'd65535);
    push_data[0] = 8'h55; push_data[1] = 8'hAA;
    push_bytes(2);
    check("queued_level", 32'(level), 32'd2);
    check("mid_data_active", 32'(tx_active), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_line", 32'(tx_line), 32'd1);
    check("arst_active", 32'(tx_active), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_ready", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx_line !== 1'b1 || tx_active !== 1'b0) quiet_ok = 1'b0;
    end
    check("post_reset_quiet", 32'(quiet_ok), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
